// File: rtl/pixel_pack_pkg.sv
// Shared widths, entry layout and defaults for the pixel pack FIFO.
package pixel_pack_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;
  localparam int ENTRY_W  = 9;

  localparam logic [NIBBLE_W-1:0] DEFAULT_PAD_VALUE = 4'h0;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } pack_entry_t;

  // Build a FIFO entry: hi nibble is the later pixel, lo nibble the earlier one.
  function automatic pack_entry_t make_entry(input logic last,
                                             input logic [NIBBLE_W-1:0] hi,
                                             input logic [NIBBLE_W-1:0] lo);
    pack_entry_t e;
    e.last = last;
    e.data = {hi, lo};
    return e;
  endfunction

endpackage

// File: rtl/pixel_pack_if.sv
// Pixel-in / byte-out handshake bundle for pixel_pack_fifo.
// slave: the packer's view; master: the view of whoever drives pixels and sinks bytes.
interface pixel_pack_if;
  import pixel_pack_pkg::*;

  logic                in_valid;
  logic [NIBBLE_W-1:0] in_data;
  logic                in_last;
  logic                in_ready;
  logic                out_valid;
  logic [BYTE_W-1:0]   out_data;
  logic                out_last;
  logic                out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
// Caller guarantees push only when not full and pop only when not empty.
// flush has priority over push/pop and empties the FIFO on the next edge.
module sync_fifo
  import pixel_pack_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state is reset; the data array is not, it is only read when count != 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage update.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pixel_pack_fifo.sv
// Packs 4-bit pixels two-per-byte and buffers the bytes with frame-end marking.
// An odd final pixel is padded with PAD_VALUE in the high nibble.
// Optional feature macro: PIXEL_PACK_COUNT_EN adds a saturating popped-byte counter.
module pixel_pack_fifo
  import pixel_pack_pkg::*;
#(
  parameter int                  DEPTH     = 4,
  parameter logic [NIBBLE_W-1:0] PAD_VALUE = DEFAULT_PAD_VALUE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pixel_pack_if.slave       bus
`ifdef PIXEL_PACK_COUNT_EN
  ,
  output logic [15:0]       byte_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [NIBBLE_W-1:0] hold_q, hold_d;
  logic                hold_valid_q, hold_valid_d;
  logic [CW-1:0]       fifo_count;
  logic [ENTRY_W-1:0]  fifo_rdata;
  pack_entry_t         push_entry;
  pack_entry_t         head;
  logic                accept;
  logic                push;
  logic                pop;

  // Readiness depends only on registered count and the rst/flush inputs.
  assign bus.in_ready  = !rst && !flush && (fifo_count != CW'(DEPTH));
  assign bus.out_valid = (fifo_count != '0) && !flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign push          = accept && (hold_valid_q || bus.in_last);

  // A lone last pixel is padded; otherwise the held nibble is the earlier pixel.
  assign push_entry = hold_valid_q ? make_entry(bus.in_last, bus.in_data, hold_q)
                                   : make_entry(1'b1, PAD_VALUE, bus.in_data);

  // Holding register: park the first pixel of a pair until its partner arrives.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (accept) begin
      if (hold_valid_q) begin
        hold_valid_d = 1'b0;
      end else if (!bus.in_last) begin
        hold_d       = bus.in_data;
        hold_valid_d = 1'b1;
      end
    end
  end

  // Holding register flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign head         = pack_entry_t'(fifo_rdata);
  assign bus.out_data = head.data;
  assign bus.out_last = head.last;

`ifdef PIXEL_PACK_COUNT_EN
  logic [15:0] byte_count_q, byte_count_d;

  // Popped-byte counter, saturating, cleared by flush.
  always_comb begin
    byte_count_d = byte_count_q;
    if (flush) begin
      byte_count_d = '0;
    end else if (pop && (byte_count_q != 16'hFFFF)) begin
      byte_count_d = byte_count_q + 16'd1;
    end
  end

  // Counter flop.
  always_ff @(posedge clk) begin
    if (rst) byte_count_q <= '0;
    else     byte_count_q <= byte_count_d;
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// Scoreboard bench for pixel_pack_fifo (DEPTH=4, PAD_VALUE=4'hA).
// Expected bytes {last, data} are queued by hand per test; a monitor pops and compares.
module tb_pixel_pack_fifo;
  import pixel_pack_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  pixel_pack_if bus ();
`ifdef PIXEL_PACK_COUNT_EN
  logic [15:0] byte_count;
`endif

  pixel_pack_fifo #(
    .DEPTH     (4),
    .PAD_VALUE (4'hA)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef PIXEL_PACK_COUNT_EN
    ,
    .byte_count (byte_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel until accepted (bounded). Call at posedge+1.
  task automatic send(input logic [3:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("accept", {31'd0, ok}, 32'd1);
  endtask

  // Pop until every expected byte has been seen, then confirm the FIFO is empty.
  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    step();
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", {31'd0, bus.out_valid}, 0);
    step();
    bus.out_ready = 1'b0;
  endtask

  // Monitor: a byte is popped at the next edge whenever out_valid && out_ready here.
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %0h expected none", {bus.out_last, bus.out_data});
      end else begin
        e = exp_q.pop_front();
        check("byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset behaviour
    step();
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 0);
    step();

    // Even frame 1,2,3,4
    exp_q.push_back(9'h021);
    exp_q.push_back(9'h143);
    bus.out_ready = 1'b1;
    send(4'h1, 1'b0);
    @(negedge clk);
    check("hold_only_out_valid", {31'd0, bus.out_valid}, 0);
    step();
    send(4'h2, 1'b0);
    @(negedge clk);
    check("latency_byte0", {31'd0, bus.out_valid}, 1);
    step();
    send(4'h3, 1'b0);
    send(4'h4, 1'b1);
    @(negedge clk);
    check("latency_byte1", {31'd0, bus.out_valid}, 1);
    step();
    drain();
`ifdef PIXEL_PACK_COUNT_EN
    check("byte_count_2", {16'd0, byte_count}, 2);
`endif

    // Odd frame 5,6,7 padded with 4'hA
    exp_q.push_back(9'h065);
    exp_q.push_back(9'h1A7);
    bus.out_ready = 1'b1;
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b1);
    drain();

    // Fill to DEPTH with out_ready low
    exp_q.push_back(9'h010);
    exp_q.push_back(9'h032);
    exp_q.push_back(9'h054);
    exp_q.push_back(9'h076);
    exp_q.push_back(9'h198);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'(i), 1'b0);
    @(negedge clk);
    check("full_in_ready", {31'd0, bus.in_ready}, 0);
    step();
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h8;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_in_ready_with_out_ready", {31'd0, bus.in_ready}, 0);
    step();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_pop", {31'd0, bus.in_ready}, 1);
    step();
    bus.in_valid = 1'b0;
    send(4'h9, 1'b1);
    @(negedge clk);
    check("refull_in_ready", {31'd0, bus.in_ready}, 0);
    step();
    drain();

    // Simultaneous push and pop at count=2
    exp_q.push_back(9'h021);
    exp_q.push_back(9'h043);
    exp_q.push_back(9'h065);
    exp_q.push_back(9'h187);
    bus.out_ready = 1'b0;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b0);
    bus.out_ready = 1'b1;
    send(4'h6, 1'b0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("count_push_pop", {29'd0, dut.u_fifo.count_q}, 2);
    step();
    send(4'h7, 1'b0);
    send(4'h8, 1'b1);
    drain();

    // Flush with a held nibble and three buffered bytes
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 7; i++) send(4'(i), 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("flush_out_valid", {31'd0, bus.out_valid}, 0);
    check("flush_in_ready", {31'd0, bus.in_ready}, 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("post_flush_out_valid", {31'd0, bus.out_valid}, 0);
    check("post_flush_count", {29'd0, dut.u_fifo.count_q}, 0);
`ifdef PIXEL_PACK_COUNT_EN
    check("byte_count_flush", {16'd0, byte_count}, 0);
`endif
    step();
    exp_q.push_back(9'h1AF);
    bus.out_ready = 1'b1;
    send(4'hF, 1'b1);
    @(negedge clk);
    check("post_flush_latency", {31'd0, bus.out_valid}, 1);
    step();
    drain();
`ifdef PIXEL_PACK_COUNT_EN
    check("byte_count_1", {16'd0, byte_count}, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
